// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the word-addressed memory controller.
package mem_ctrl_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int DEF_AWIDTH = 5;
    localparam int DEF_WWIDTH = 8;
    localparam int RSP_DEPTH  = 2;

endpackage

// File: rtl/mem_ctrl_rsp_fifo.sv
// In-order response buffer of RSP_DEPTH entries with push/pop/count.
module rsp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(RSP_DEPTH + 1),
    localparam int PW = $clog2(RSP_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] data [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full buffer can still take a push when the head leaves on the same edge.
    assign do_push = push && ((count != CW'(RSP_DEPTH)) || do_pop);
    assign valid   = (count != '0);
    assign head    = data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (do_push) begin
                data[wr_ptr] <= push_data;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port word memory with byte enables, zeroing INIT sequence,
// one-cycle read stage and a small in-order response buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int WWIDTH = DEF_WWIDTH,
    localparam int BEWIDTH = WWIDTH / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AWIDTH-1:0]  req_addr,
    input  logic [WWIDTH-1:0]  req_wdata,
    input  logic [BEWIDTH-1:0] req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WWIDTH-1:0]  rsp_rdata,
    input  logic               clr,
    output logic               init_done
);

    localparam int DEPTH = 2 ** AWIDTH;

    state_t            state;
    logic [AWIDTH-1:0] ptr;
    logic              rd_valid;
    logic [WWIDTH-1:0] rd_data;
    logic [WWIDTH-1:0] mem [DEPTH];
    logic [1:0]        count;
    logic [1:0]        occ;
    logic              accept;
    logic              wr_fire;
    logic              rd_fire;

    // Reads in flight plus buffered responses bound how many we may accept.
    assign occ       = count + {1'b0, rd_valid};
    assign req_ready = (state == RUN) && !clr && (occ < 2'd2);
    assign accept    = req_valid && req_ready;
    assign wr_fire   = accept && req_write;
    assign rd_fire   = accept && !req_write;
    assign init_done = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            ptr      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            unique case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (clr && !rd_valid && (count == '0)) begin
                        state <= INIT;
                        ptr   <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Array is cleared only by walking INIT, never by reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BEWIDTH; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
        if (rd_fire) begin
            rd_data <= mem[req_addr];
        end
    end

    rsp_fifo #(
        .WIDTH(WWIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_valid),
        .push_data (rd_data),
        .pop       (rsp_ready),
        .head      (rsp_rdata),
        .valid     (rsp_valid),
        .count     (count)
    );

endmodule
